// File: rtl/mpy_acc_stage.sv
// mpy_acc_stage
// Accumulates the signed 16-bit products of a pipelined multiplier into a
// saturating dot-product and hands each finished vector result to a
// valid/ready consumer. A valid/last tag pipeline runs alongside the
// multiplier so every product is matched to the operand issue that made it.
//
// Ports:
//   clk        rising-edge clock shared with the multiplier
//   rst_n      asynchronous active-low reset
//   in_valid   operands are on the multiplier a/b inputs this cycle
//   in_last    with in_valid: final term of the current vector
//   in_ready   block accepts an operand issue this cycle
//   product    signed multiplier output (LATENCY cycles after issue)
//   out_valid  result/count/ovf hold a complete vector
//   out_ready  consumer takes the result
//   result     signed saturated sum of the vector's products
//   count      number of terms in result (wraps modulo 2^CNT_W)
//   ovf        saturation happened at least once in this vector
module mpy_acc_stage #(
    parameter int LATENCY = 14,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    input  logic signed [15:0]      product,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] result,
    output logic [CNT_W-1:0]        count,
    output logic                    ovf
);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Rails expressed at ACC_W+1 bits so the unclamped sum can be compared
    // directly against them.
    localparam logic signed [ACC_W:0] POS_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] NEG_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    state_t                  state;
    state_t                  state_nxt;
    logic [LATENCY-1:0]      vld_pipe;
    logic [LATENCY-1:0]      last_pipe;
    logic                    first;
    logic                    accept;
    logic                    hit;
    logic                    hit_last;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W-1:0] sat_val;
    logic                    sat;

    // Accept depends only on the registered state, so it never loops
    // through the in_ready output logic.
    assign accept   = in_valid && (state == ACCUM);
    assign hit      = vld_pipe[LATENCY-1];
    assign hit_last = hit && last_pipe[LATENCY-1];

    // Tag pipeline: one slot per multiplier stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            vld_pipe[0]  <= accept;
            last_pipe[0] <= accept && in_last;
            for (int i = 1; i < LATENCY; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    // One widened add per arriving term, then clamp. The first term of a
    // vector starts from zero instead of the previous vector's result,
    // which stays visible on the outputs until this moment.
    always_comb begin
        sum     = (first ? '0 : {result[ACC_W-1], result})
                + {{(ACC_W-15){product[15]}}, product};
        sat     = 1'b0;
        sat_val = sum[ACC_W-1:0];
        if (sum > POS_MAX) begin
            sat     = 1'b1;
            sat_val = POS_MAX[ACC_W-1:0];
        end else if (sum < NEG_MIN) begin
            sat     = 1'b1;
            sat_val = NEG_MIN[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            first  <= 1'b1;
        end else if (hit) begin
            result <= sat_val;
            count  <= first ? CNT_W'(1) : count + 1'b1;
            ovf    <= first ? sat : (ovf | sat);
            first  <= 1'b0;
        end else if (state == DONE && out_ready) begin
            first  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // Issue is closed from the last accepted term until the result is taken.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && in_last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (hit_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

endmodule
